// File: rtl/countdown_counter_pkg.sv
// Shared command codes, state encoding and add increments for the countdown counter.
// Optional build macro used by the top level: COUNTDOWN_AUTOCLEAR_EN.
package timer_pkg;

  localparam logic [3:0] CMD_HOLD    = 4'h0;
  localparam logic [3:0] CMD_CLEAR   = 4'h1;
  localparam logic [3:0] CMD_ADD_TEN = 4'h2;
  localparam logic [3:0] CMD_ADD_MIN = 4'h3;
  localparam logic [3:0] CMD_START   = 4'h4;
  localparam logic [3:0] CMD_PAUSE   = 4'h5;

  localparam int INC_TEN = 10;
  localparam int INC_MIN = 60;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/countdown_counter_if.sv
// Controller-to-counter bus: command code/qualifier in, remaining time and status out.
interface countdown_counter_if #(
  parameter int WIDTH = 12
);

  logic [3:0]       CounterInput;
  logic             CounterEnable;
  logic [WIDTH-1:0] PresentTime;
  logic             Running;
  logic             Done;

  modport master (
    output CounterInput,
    output CounterEnable,
    input  PresentTime,
    input  Running,
    input  Done
  );

  modport slave (
    input  CounterInput,
    input  CounterEnable,
    output PresentTime,
    output Running,
    output Done
  );

endinterface

// File: rtl/countdown_counter_tick_prescaler.sv
// Free-running divider producing a one-cycle Tick every TICK_DIV enabled cycles.
// Count holds its value while Enable is low; Clear forces it back to zero.
module tick_prescaler #(
  parameter  int TICK_DIV = 10,
  localparam int CW       = $clog2(TICK_DIV)
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          Clear,
  input  logic          Enable,
  output logic          Tick,
  output logic [CW-1:0] Count
);

  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Next count: clear wins, otherwise advance and wrap while enabled.
  always_comb begin
    count_d = count_q;
    if (Clear) begin
      count_d = '0;
    end else if (Enable) begin
      if (count_q == LAST) begin
        count_d = '0;
      end else begin
        count_d = count_q + CW'(1);
      end
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign Tick  = Enable & (count_q == LAST);
  assign Count = count_q;

endmodule

// File: rtl/countdown_counter.sv
// Countdown timer: saturating add commands build the time, a prescaled tick counts it down.
// Build macro COUNTDOWN_AUTOCLEAR_EN makes DONE fall back to IDLE after DONE_HOLD ticks.
module countdown_counter
  import timer_pkg::*;
#(
  parameter int WIDTH     = 12,
  parameter int TICK_DIV  = 10,
  parameter int MAX_TIME  = 4095,
  parameter int DONE_HOLD = 5
) (
  input  logic                Clock,
  input  logic                Reset,
  countdown_counter_if.slave  bus
);

  localparam int            CW     = $clog2(TICK_DIV);
  localparam logic [WIDTH:0] CEIL_W = (WIDTH + 1)'(MAX_TIME);
  localparam logic [WIDTH:0] TEN_W  = (WIDTH + 1)'(INC_TEN);
  localparam logic [WIDTH:0] MIN_W  = (WIDTH + 1)'(INC_MIN);

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] time_q;
  logic [WIDTH-1:0] time_d;
  logic             running_q;
  logic             done_q;

  logic [3:0]       cmd_s;
  logic             is_add_s;
  logic [WIDTH-1:0] add_res_s;
  logic             presc_clear_s;
  logic             presc_en_s;
  logic             tick_s;
  logic [CW-1:0]    presc_count_unused_s;

`ifdef COUNTDOWN_AUTOCLEAR_EN
  localparam int HW = $clog2(DONE_HOLD + 1);
  logic [HW-1:0] hold_q;
  logic [HW-1:0] hold_d;
`endif

  // The sum is one bit wider than the time so an overflow can never wrap.
  function automatic logic [WIDTH-1:0] sat_add(input logic [WIDTH-1:0] base,
                                               input logic [WIDTH:0]   inc);
    logic [WIDTH:0] sum;
    sum = {1'b0, base} + inc;
    if (sum > CEIL_W) begin
      return CEIL_W[WIDTH-1:0];
    end else begin
      return sum[WIDTH-1:0];
    end
  endfunction

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .Clock  (Clock),
    .Reset  (Reset),
    .Clear  (presc_clear_s),
    .Enable (presc_en_s),
    .Tick   (tick_s),
    .Count  (presc_count_unused_s)
  );

  // Command decode: a masked bus reads as HOLD, so counting never stalls.
  always_comb begin
    cmd_s     = bus.CounterEnable ? bus.CounterInput : CMD_HOLD;
    is_add_s  = (cmd_s == CMD_ADD_TEN) || (cmd_s == CMD_ADD_MIN);
    add_res_s = sat_add(time_q, (cmd_s == CMD_ADD_MIN) ? MIN_W : TEN_W);
  end

  // Next-state, next-time and prescaler control.
  always_comb begin
    state_d       = state_q;
    time_d        = time_q;
    presc_clear_s = 1'b0;
    presc_en_s    = 1'b0;
`ifdef COUNTDOWN_AUTOCLEAR_EN
    hold_d        = '0;
`endif
    if (cmd_s == CMD_CLEAR) begin
      state_d       = ST_IDLE;
      time_d        = '0;
      presc_clear_s = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (is_add_s) begin
            time_d = add_res_s;
          end else if ((cmd_s == CMD_START) && (time_q != '0)) begin
            state_d       = ST_RUN;
            presc_clear_s = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_RUN: begin
          // The tick lands before a same-edge PAUSE; reaching zero overrides the pause.
          presc_en_s = 1'b1;
          if (tick_s) begin
            time_d = time_q - WIDTH'(1);
          end else begin
            time_d = time_q;
          end
          if (tick_s && (time_q == WIDTH'(1))) begin
            state_d = ST_DONE;
          end else if (cmd_s == CMD_PAUSE) begin
            state_d = ST_PAUSED;
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_PAUSED: begin
          if (is_add_s) begin
            time_d = add_res_s;
          end else if ((cmd_s == CMD_START) && (time_q != '0)) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_PAUSED;
          end
        end
        ST_DONE: begin
          if (is_add_s) begin
            time_d        = add_res_s;
            state_d       = ST_IDLE;
            presc_clear_s = 1'b1;
          end else begin
`ifdef COUNTDOWN_AUTOCLEAR_EN
            presc_en_s = 1'b1;
            if (tick_s) begin
              if (hold_q == HW'(DONE_HOLD - 1)) begin
                state_d = ST_IDLE;
                hold_d  = '0;
              end else begin
                hold_d = hold_q + HW'(1);
              end
            end else begin
              hold_d = hold_q;
            end
`else
            state_d = ST_DONE;
`endif
          end
        end
        default: begin
          state_d       = ST_IDLE;
          time_d        = '0;
          presc_clear_s = 1'b1;
        end
      endcase
    end
  end

  // State, time and status registers; status is decoded from the next state.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q   <= ST_IDLE;
      time_q    <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      time_q    <= time_d;
      running_q <= (state_d == ST_RUN);
      done_q    <= (state_d == ST_DONE);
    end
  end

`ifdef COUNTDOWN_AUTOCLEAR_EN
  // Ticks spent in DONE so far.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      hold_q <= '0;
    end else begin
      hold_q <= hold_d;
    end
  end
`endif

  assign bus.PresentTime = time_q;
  assign bus.Running     = running_q;
  assign bus.Done        = done_q;

endmodule

// File: tb/tb_countdown_counter.sv
// Directed and randomized checks of countdown_counter against a cycle-level behavioural model.
module tb_countdown_counter;

  localparam int TICK_DIV  = 4;
  localparam int MAX_TIME  = 4095;
  localparam int DONE_HOLD = 5;

  localparam logic [3:0] C_HOLD  = 4'h0;
  localparam logic [3:0] C_CLEAR = 4'h1;
  localparam logic [3:0] C_TEN   = 4'h2;
  localparam logic [3:0] C_MIN   = 4'h3;
  localparam logic [3:0] C_START = 4'h4;
  localparam logic [3:0] C_PAUSE = 4'h5;

  localparam int M_IDLE   = 0;
  localparam int M_RUN    = 1;
  localparam int M_PAUSED = 2;
  localparam int M_DONE   = 3;

  logic Clock = 1'b0;
  logic Reset = 1'b1;

  int checks = 0;
  int fails  = 0;

  int m_time     = 0;
  int m_mode     = M_IDLE;
  int m_phase    = 0;
  int m_done_cyc = 0;

  countdown_counter_if #(.WIDTH(12)) bus ();

  countdown_counter #(
    .WIDTH     (12),
    .TICK_DIV  (TICK_DIV),
    .MAX_TIME  (MAX_TIME),
    .DONE_HOLD (DONE_HOLD)
  ) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".time"}, 32'(bus.PresentTime), 32'(m_time));
    check({tag, ".running"}, 32'(bus.Running), (m_mode == M_RUN) ? 32'd1 : 32'd0);
    check({tag, ".done"}, 32'(bus.Done), (m_mode == M_DONE) ? 32'd1 : 32'd0);
  endtask

  function automatic int add_amount(input int cmd);
    if (cmd == 2) return 10;
    if (cmd == 3) return 60;
    return 0;
  endfunction

  function automatic int clamp(input int v);
    return (v > MAX_TIME) ? MAX_TIME : v;
  endfunction

  task automatic model_reset();
    m_time     = 0;
    m_mode     = M_IDLE;
    m_phase    = 0;
    m_done_cyc = 0;
  endtask

  // One clock edge of the behavioural model, from the command rules and the one-second period.
  task automatic model_step(input logic [3:0] c, input logic en);
    int cmd;
    int inc;
    cmd = en ? int'(c) : 0;
    inc = add_amount(cmd);
    if (cmd == 1) begin
      model_reset();
    end else begin
      case (m_mode)
        M_IDLE: begin
          if (inc != 0) m_time = clamp(m_time + inc);
          else if (cmd == 4 && m_time != 0) begin
            m_mode  = M_RUN;
            m_phase = 0;
          end
        end
        M_RUN: begin
          m_phase = m_phase + 1;
          if (m_phase == TICK_DIV) begin
            m_phase = 0;
            m_time  = m_time - 1;
          end
          if (m_time == 0) begin
            m_mode     = M_DONE;
            m_done_cyc = 0;
          end else if (cmd == 5) begin
            m_mode = M_PAUSED;
          end
        end
        M_PAUSED: begin
          if (inc != 0) m_time = clamp(m_time + inc);
          else if (cmd == 4) m_mode = M_RUN;
        end
        default: begin
          if (inc != 0) begin
            m_time = clamp(inc);
            m_mode = M_IDLE;
          end else begin
`ifdef COUNTDOWN_AUTOCLEAR_EN
            m_done_cyc = m_done_cyc + 1;
            if (m_done_cyc == DONE_HOLD * TICK_DIV) m_mode = M_IDLE;
`endif
          end
        end
      endcase
    end
  endtask

  // Drive at the falling edge, advance the model at the rising edge, compare at the next falling edge.
  task automatic cycle(input logic [3:0] c, input logic en, input string tag);
    bus.CounterInput  = c;
    bus.CounterEnable = en;
    @(posedge Clock);
    model_step(c, en);
    @(negedge Clock);
    check_model(tag);
  endtask

  initial begin
    logic [3:0] rc;
    logic       ren;
    int         r;
    int         guard;

    bus.CounterInput  = C_HOLD;
    bus.CounterEnable = 1'b0;
    @(negedge Clock);
    check_model("reset");
    check("reset.time_const", 32'(bus.PresentTime), 32'd0);
    Reset = 1'b0;

    cycle(C_MIN, 1'b1, "add_min");
    cycle(C_TEN, 1'b1, "add_ten1");
    cycle(C_TEN, 1'b1, "add_ten2");
    check("add80", 32'(bus.PresentTime), 32'd80);

    // Reach exactly 2 with a fresh prescaler: pause on the tick that lands on 2.
    cycle(C_CLEAR, 1'b1, "clr1");
    cycle(C_TEN, 1'b1, "load10");
    cycle(C_START, 1'b1, "start10");
    guard = 0;
    while (!(m_time == 3 && m_phase == TICK_DIV - 1) && guard < 100) begin
      cycle(C_HOLD, 1'b1, "run10");
      guard++;
    end
    check("reach3_bound", (guard < 100) ? 32'd1 : 32'd0, 32'd1);
    cycle(C_PAUSE, 1'b1, "pause_on_tick");
    check("pause_tick_time", 32'(bus.PresentTime), 32'd2);
    check("pause_tick_run", 32'(bus.Running), 32'd0);
    cycle(C_START, 1'b1, "start2");
    check("start2_run", 32'(bus.Running), 32'd1);
    repeat (3) cycle(C_HOLD, 1'b1, "run2a");
    check("run2_before_tick", 32'(bus.PresentTime), 32'd2);
    cycle(C_HOLD, 1'b1, "run2b");
    check("run2_tick4", 32'(bus.PresentTime), 32'd1);
    repeat (4) cycle(C_HOLD, 1'b1, "run2c");
    check("run2_done", 32'(bus.Done), 32'd1);
    check("run2_notrun", 32'(bus.Running), 32'd0);
    check("run2_zero", 32'(bus.PresentTime), 32'd0);
    repeat (3) cycle(C_HOLD, 1'b1, "done_hold");

    // Saturation at the ceiling.
    cycle(C_CLEAR, 1'b1, "clr2");
    repeat (68) cycle(C_MIN, 1'b1, "fill");
    cycle(C_TEN, 1'b1, "fill_ten");
    check("fill4090", 32'(bus.PresentTime), 32'd4090);
    cycle(C_MIN, 1'b1, "sat_min");
    check("sat_min", 32'(bus.PresentTime), 32'd4095);
    cycle(C_TEN, 1'b1, "sat_ten");
    check("sat_ten", 32'(bus.PresentTime), 32'd4095);
    cycle(C_CLEAR, 1'b1, "clr3");
    cycle(C_START, 1'b1, "start_zero");
    check("start_zero_run", 32'(bus.Running), 32'd0);

    // Pause keeps the prescaler phase.
    repeat (5) cycle(C_TEN, 1'b1, "load50");
    cycle(C_START, 1'b1, "start50");
    cycle(C_HOLD, 1'b1, "run50");
    cycle(C_PAUSE, 1'b1, "pause50");
    repeat (20) cycle(C_HOLD, 1'b1, "paused50");
    check("paused_frozen", 32'(bus.PresentTime), 32'd50);
    cycle(C_START, 1'b1, "resume50");
    cycle(C_HOLD, 1'b1, "resume_a");
    check("resume_a_time", 32'(bus.PresentTime), 32'd50);
    cycle(C_HOLD, 1'b1, "resume_b");
    check("resume_49", 32'(bus.PresentTime), 32'd49);

    // CLEAR on the tick edge, then asynchronous reset mid-run.
    cycle(C_CLEAR, 1'b1, "clr4");
    repeat (3) cycle(C_TEN, 1'b1, "load30");
    cycle(C_START, 1'b1, "start30");
    repeat (TICK_DIV - 1) cycle(C_HOLD, 1'b1, "run30");
    cycle(C_CLEAR, 1'b1, "clear_on_tick");
    check("clear_tick_time", 32'(bus.PresentTime), 32'd0);
    check("clear_tick_run", 32'(bus.Running), 32'd0);
    repeat (3) cycle(C_TEN, 1'b1, "reload30");
    cycle(C_START, 1'b1, "restart30");
    repeat (5) cycle(C_HOLD, 1'b1, "rerun30");
    #2;
    Reset = 1'b1;
    #1;
    check("async_rst_time", 32'(bus.PresentTime), 32'd0);
    check("async_rst_run", 32'(bus.Running), 32'd0);
    check("async_rst_done", 32'(bus.Done), 32'd0);
    model_reset();
    @(negedge Clock);
    Reset = 1'b0;

    // A masked CLEAR never stalls the countdown.
    cycle(C_TEN, 1'b1, "load10b");
    cycle(C_START, 1'b1, "start10b");
    guard = 0;
    while (m_time != 5 && guard < 100) begin
      cycle(C_HOLD, 1'b1, "run_to5");
      guard++;
    end
    guard = 0;
    while (m_mode != M_DONE && guard < 100) begin
      cycle(C_CLEAR, 1'b0, "masked_clear");
      guard++;
    end
    check("masked_done", 32'(bus.Done), 32'd1);
`ifdef COUNTDOWN_AUTOCLEAR_EN
    repeat (DONE_HOLD * TICK_DIV - 1) cycle(C_HOLD, 1'b1, "autoclr_wait");
    check("autoclr_still_done", 32'(bus.Done), 32'd1);
    cycle(C_HOLD, 1'b1, "autoclr_edge");
    check("autoclr_dropped", 32'(bus.Done), 32'd0);
`else
    repeat (DONE_HOLD * TICK_DIV + 4) cycle(C_HOLD, 1'b1, "done_persist");
    check("done_persists", 32'(bus.Done), 32'd1);
`endif
    cycle(C_MIN, 1'b1, "add_from_done");
    check("add_from_done", 32'(bus.PresentTime), 32'd60);

    // Randomized command traffic.
    for (int i = 0; i < 800; i++) begin
      r = $urandom_range(0, 99);
      if (r < 45)      rc = C_HOLD;
      else if (r < 48) rc = C_CLEAR;
      else if (r < 63) rc = C_TEN;
      else if (r < 71) rc = C_MIN;
      else if (r < 81) rc = C_START;
      else if (r < 87) rc = C_PAUSE;
      else             rc = 4'($urandom_range(6, 15));
      ren = ($urandom_range(0, 9) != 0);
      if (m_mode == M_RUN && rc == C_START) rc = C_HOLD;
      cycle(rc, ren, "random");
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/countdown_counter.md
Name: countdown_counter

Overview:
- Time-keeping counter on the far end of the controller-to-counter interface. It consumes the controller's CounterInput/CounterEnable command bus and produces the PresentTime value the controller reads back.
- Holds a 12-bit seconds value. Users build it up with add commands, then a prescaled 1-second tick counts it down to zero while running.
- Reports Running and Done status back to the controller and display logic.

Parameters:
- WIDTH, 12, bit width of PresentTime (seconds).
- TICK_DIV, 10, clock cycles per 1-second tick (board build overrides to the clock rate). Must be >= 2.
- MAX_TIME, 4095, saturation ceiling for add commands. Must be <= 2^WIDTH-1.
- DONE_HOLD, 5, ticks spent in DONE before auto-clear (optional feature only).

Ports:
- Clock, input, 1, single system clock, rising edge.
- Reset, input, 1, asynchronous, active-high reset.
- CounterInput, input, 4, command code, sampled on Clock edges when CounterEnable=1.
- CounterEnable, input, 1, command qualifier; when 0, CounterInput is ignored.
- PresentTime, output, WIDTH, current remaining time in seconds, registered.
- Running, output, 1, high while in RUN.
- Done, output, 1, high while in DONE.

Behaviour:
- Reset (async, Reset=1): PresentTime=0, Running=0, Done=0, state=IDLE, prescaler=0.
- Command codes (CounterInput, effective at the edge where CounterEnable=1; results visible on outputs the next cycle):
  - 0x0 HOLD: no action.
  - 0x1 CLEAR: PresentTime=0, go to IDLE, prescaler=0. Honoured from every state.
  - 0x2 ADD_TEN: PresentTime = min(PresentTime+10, MAX_TIME).
  - 0x3 ADD_MIN: PresentTime = min(PresentTime+60, MAX_TIME).
  - 0x4 START: if PresentTime != 0, go to RUN with prescaler=0; if PresentTime = 0, ignored.
  - 0x5 PAUSE: RUN -> PAUSED; ignored in other states.
  - 0x6-0xF: treated as HOLD.
- Arithmetic for adds:
  - Computed WIDTH+1 bits wide, then clamped to MAX_TIME.
  - PresentTime never wraps.
- States:
  - IDLE: accepts ADD_TEN, ADD_MIN, START, CLEAR.
  - RUN:
    - ADD commands ignored; prescaler counts 0..TICK_DIV-1.
    - On prescaler = TICK_DIV-1: prescaler wraps to 0 and PresentTime decrements by 1.
    - If that decrement reaches 0, go to DONE on the same edge.
  - PAUSED: prescaler frozen (value retained). Accepts ADD_TEN, ADD_MIN, CLEAR. START resumes RUN with the prescaler retained, not cleared.
  - DONE: PresentTime=0, Done=1. ADD commands load the new value and go to IDLE. CLEAR goes to IDLE.
- Latency: first decrement occurs exactly TICK_DIV cycles after the START edge.
- Priority:
  - CLEAR beats a tick on the same edge.
  - PAUSE on the same edge as a tick: the tick is applied first, then the block pauses. If that tick reaches 0, DONE wins.
- Outputs are registered and decoded from state: Running=(state==RUN), Done=(state==DONE).
- CounterEnable=0 never stalls counting; it only masks commands.
- Reset asserted mid-RUN: immediate return to reset values, independent of Clock.

Optional Feature:
- Macro: COUNTDOWN_AUTOCLEAR_EN.
- Defined: DONE counts DONE_HOLD ticks using the prescaler, then returns to IDLE and Done drops. CLEAR or ADD still exit DONE early.
- Undefined: DONE persists until CLEAR or ADD; the prescaler is idle in DONE.

Decomposition:
- Package timer_pkg holds:
  - command localparams CMD_HOLD, CMD_CLEAR, CMD_ADD_TEN, CMD_ADD_MIN, CMD_START, CMD_PAUSE;
  - state encoding ST_IDLE, ST_RUN, ST_PAUSED, ST_DONE;
  - the increment constants 10 and 60.
- One sub-module, tick_prescaler:
  - inputs Clock, Reset, Clear, Enable;
  - outputs a one-cycle Tick and the count;
  - parameter TICK_DIV.

Test Plan (TICK_DIV=4):
- Reset, then ADD_MIN, ADD_TEN, ADD_TEN -> PresentTime=80, Running=0, Done=0.
- PresentTime=2, START -> Running=1 next cycle; PresentTime=1 at START+4 cycles; PresentTime=0 and Done=1, Running=0 at START+8.
- MAX_TIME=4095, PresentTime=4090, ADD_MIN -> PresentTime=4095 (saturated, no wrap). START with PresentTime=0 -> stays IDLE, Running=0.
- RUN at 50, PAUSE after 2 prescaler cycles, wait 20 cycles -> PresentTime=50 (frozen). START -> decrement to 49 after 2 more cycles (prescaler retained).
- RUN at 30: CLEAR coincident with a tick edge -> PresentTime=0, IDLE. Reset pulsed mid-RUN between clock edges -> outputs 0 immediately.
- CounterEnable=0 with CounterInput=CMD_CLEAR during RUN at 5 -> still counts down to DONE. Optional feature on, DONE_HOLD=5 -> Done drops 20 cycles after DONE entry.
